// File: rtl/mem_sram_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the shared SRAM-like port.
// Latency: none, signal container only.
// Backpressure: requests hold until *_addr_ok; responses are single-cycle *_data_ok pulses.
// Ports: inst_* (fetch side), data_* (memory-stage side), sram_* (memory side).
interface mem_sram_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        sram_req;
    logic        sram_wr;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_wdata;
    logic        sram_addr_ok;
    logic        sram_data_ok;
    logic [31:0] sram_rdata;

    // Arbiter view.
    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  sram_addr_ok, sram_data_ok, sram_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata
    );

    // Requester + memory view.
    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output sram_addr_ok, sram_data_ok, sram_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata
    );
endinterface

// File: rtl/mem_sram_arbiter.sv
// Two-requester arbiter (fetch, data) onto one SRAM-like port, one transaction outstanding.
// Latency: zero added cycles; addr_ok and data_ok/rdata pass through combinationally.
// Backpressure: loser and stalled winner hold req; at most one transaction per 2 cycles.
// Ports: clk, resetn (async active-low), bus (slave modport), err_spurious (sticky).
module mem_sram_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              resetn,
    mem_sram_arbiter_if.slave bus,
    output logic              err_spurious
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;      // 0 = inst, 1 = data
    logic [2:0] starve_q, starve_d;
    logic       err_q;

    logic       grant_data, grant_inst;
    logic       drive;                 // a request is being presented on the sram port
    logic       sel_data;              // which requester's fields drive the sram port

    always_comb begin
        // Gating with resetn keeps every output at zero while reset is held,
        // even if a requester is already asserting req.
        grant_data = resetn && bus.data_req && !(bus.inst_req && (starve_q == STARVE_LIM));
        grant_inst = resetn && bus.inst_req && !grant_data;

        state_d          = state_q;
        owner_d          = owner_q;
        starve_d         = starve_q;
        drive            = 1'b0;
        sel_data         = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'd0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
        bus.sram_req     = 1'b0;
        bus.sram_wr      = 1'b0;
        bus.sram_size    = 2'd0;
        bus.sram_addr    = 32'd0;
        bus.sram_wstrb   = 4'd0;
        bus.sram_wdata   = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (grant_data || grant_inst) begin
                    drive    = 1'b1;
                    sel_data = grant_data;
                    owner_d  = grant_data;
                    if (grant_inst) begin
                        starve_d = 3'd0;
                    end else if (bus.inst_req && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + 3'd1;
                    end
                    state_d = bus.sram_addr_ok ? S_DATA : S_REQ;
                end
            end
            S_REQ: begin
                // Grant is locked; no re-arbitration while the memory stalls.
                drive    = 1'b1;
                sel_data = owner_q;
                if (bus.sram_addr_ok) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.sram_data_ok) begin
                    state_d = S_IDLE;
                    if (owner_q) begin
                        bus.data_data_ok = 1'b1;
                        bus.data_rdata   = bus.sram_rdata;
                    end else begin
                        bus.inst_data_ok = 1'b1;
                        bus.inst_rdata   = bus.sram_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (drive) begin
            bus.sram_req = 1'b1;
            if (sel_data) begin
                bus.sram_wr      = bus.data_wr;
                bus.sram_size    = bus.data_size;
                bus.sram_addr    = bus.data_addr;
                bus.sram_wstrb   = bus.data_wstrb;
                bus.sram_wdata   = bus.data_wdata;
                bus.data_addr_ok = bus.sram_addr_ok;
            end else begin
                // Fetch is always a word read.
                bus.sram_size    = 2'd2;
                bus.sram_addr    = bus.inst_addr;
                bus.inst_addr_ok = bus.sram_addr_ok;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            starve_q <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            // A response with nothing outstanding is dropped but remembered.
            if (bus.sram_data_ok && (state_q != S_DATA)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_spurious = err_q;

endmodule
